// File: rtl/core_pkg.sv
// Shared types for the core slot: the 32-bit word type and the dump FSM states.
package core_pkg;

    typedef logic [31:0] r32;

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_RECV  = 3'd1,
        S_SEND  = 3'd2,
        S_SUM   = 3'd3,
        S_DONE  = 3'd4
    } dump_state_t;

endpackage

// File: rtl/loopback_dump_core_if.sv
// Bus bundles of the core slot: instruction fetch, data cache, UART send and
// UART receive request ports.
//
// Handshakes:
//   instr  : addr is presented in cycle n, instr carries mem[addr] in cycle n+1.
//   send   : the master may raise en only when busy was low at the issuing edge;
//            en is a one-cycle pulse and content is valid while en is high.
//            busy rising in the cycle after a pulse does not cancel that pulse.
//   recv   : size counts queued words and rd shows the head; a cycle with en
//            high pops the head, and en must only be high while size != 0.

interface IInstr;
    import core_pkg::*;
    r32 addr;
    r32 instr;
    modport master (output addr, input instr);
    modport slave  (input addr, output instr);
endinterface

interface ICache;
    import core_pkg::*;
    r32   addr;
    r32   wdata;
    logic wr_en;
    logic rd_en;
    r32   rdata;
    modport master (output addr, output wdata, output wr_en, output rd_en, input rdata);
    modport slave  (input addr, input wdata, input wr_en, input rd_en, output rdata);
endinterface

interface ISendRequest;
    import core_pkg::*;
    logic busy;
    logic en;
    r32   content;
    modport master (input busy, output en, output content);
    modport slave  (output busy, input en, input content);
endinterface

interface IRecvRequest;
    import core_pkg::*;
    r32   size;
    r32   rd;
    logic en;
    modport master (input size, input rd, output en);
    modport slave  (output size, output rd, input en);
endinterface

// File: rtl/dump_buffer.sv
// Word buffer for the dump core: one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module dump_buffer
    import core_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  r32            wdata,
    input  logic [AW-1:0] raddr,
    output r32            rdata
);

    r32 mem [DEPTH];

    // Single write port, one word per cycle.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/loopback_dump_core.sv
// Bring-up stand-in for the CPU: fetches the first N_INSTR instruction words,
// pops N_DATA words from the UART receive queue, then echoes all buffered
// words over UART transmit (optionally reversed, optionally followed by their
// 32-bit wrap-around sum) and parks in a sticky done state.
module loopback_dump_core
    import core_pkg::*;
#(
    parameter int N_INSTR    = 10,
    parameter int N_DATA     = 10,
    parameter int BUF_DEPTH  = 64,
    parameter int REVERSE    = 0,
    parameter int APPEND_SUM = 1
) (
    input  logic               clock,
    input  logic               reset,
    IInstr.master              instr_mem,
    ICache.master              cache,
    ISendRequest.master        io_send,
    IRecvRequest.master        io_recv,
    output logic               done,
    output dump_state_t        state
);

    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int L  = N_INSTR + N_DATA;

    localparam logic [CW-1:0] ONE       = CW'(1);
    localparam logic [CW-1:0] N_INSTR_C = CW'(N_INSTR);
    localparam logic [CW-1:0] N_DATA_C  = CW'(N_DATA);
    localparam logic [CW-1:0] L_LAST_C  = CW'(L - 1);

    // Empty phases are skipped by choosing the successor state up front.
    localparam dump_state_t AFTER_FETCH = (N_DATA > 0) ? S_RECV : S_SEND;
    localparam dump_state_t START_STATE = (N_INSTR > 0) ? S_FETCH : AFTER_FETCH;
    localparam dump_state_t AFTER_SEND  = (APPEND_SUM != 0) ? S_SUM : S_DONE;

    if (N_INSTR < 0 || N_DATA < 0 || L > BUF_DEPTH || L == 0) begin : g_bad_params
        $error("loopback_dump_core: need 0 < N_INSTR + N_DATA <= BUF_DEPTH");
    end

    logic [CW-1:0] k;        // fetch step, doubles as the fetch address
    logic [CW-1:0] j;        // received-word count
    logic [CW-1:0] i;        // sent-word count; buffer index derived from it
    r32            addr_q;
    r32            sum;
    r32            content;
    logic          send_en;

    logic          recv_en;
    logic          issue;
    logic          last_word;
    logic [CW-1:0] rd_idx;
    logic          buf_we;
    logic [AW-1:0] buf_waddr;
    r32            buf_wdata;
    r32            buf_rdata;

    // Pop is combinational so it can never fire against an empty queue.
    assign recv_en   = (state == S_RECV) && (io_recv.size != '0);
    // A new word goes out only when the sink is idle and no pulse is in flight.
    assign issue     = !io_send.busy && !send_en;
    assign last_word = (i == L_LAST_C);
    assign rd_idx    = (REVERSE != 0) ? (L_LAST_C - i) : i;

    // Buffer write steering: fetched words land at k-1, received words follow them.
    always_comb begin
        buf_we    = 1'b0;
        buf_waddr = '0;
        buf_wdata = instr_mem.instr;
        if (state == S_FETCH && k != '0) begin
            buf_we    = 1'b1;
            buf_waddr = AW'(k - ONE);
            buf_wdata = instr_mem.instr;
        end else if (recv_en) begin
            buf_we    = 1'b1;
            buf_waddr = AW'(N_INSTR_C + j);
            buf_wdata = io_recv.rd;
        end
    end

    dump_buffer #(
        .DEPTH (BUF_DEPTH),
        .AW    (AW)
    ) u_buffer (
        .clock (clock),
        .we    (buf_we),
        .waddr (buf_waddr),
        .wdata (buf_wdata),
        .raddr (AW'(rd_idx)),
        .rdata (buf_rdata)
    );

    // Main sequencer: fetch, receive, send, optional checksum, then park.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= START_STATE;
            k       <= '0;
            j       <= '0;
            i       <= '0;
            addr_q  <= '0;
            sum     <= '0;
            content <= '0;
            send_en <= 1'b0;
            done    <= 1'b0;
        end else begin
            send_en <= 1'b0;
            case (state)
                S_FETCH: begin
                    if (k != '0) begin
                        sum <= sum + instr_mem.instr;
                    end
                    if (k == N_INSTR_C) begin
                        k      <= '0;
                        addr_q <= '0;
                        state  <= AFTER_FETCH;
                    end else begin
                        k      <= k + ONE;
                        addr_q <= r32'(k + ONE);
                    end
                end
                S_RECV: begin
                    if (recv_en) begin
                        sum <= sum + io_recv.rd;
                        if (j == N_DATA_C - ONE) begin
                            j     <= '0;
                            state <= S_SEND;
                        end else begin
                            j <= j + ONE;
                        end
                    end
                end
                S_SEND: begin
                    if (issue) begin
                        send_en <= 1'b1;
                        content <= buf_rdata;
                        if (last_word) begin
                            i     <= '0;
                            state <= AFTER_SEND;
                            done  <= (AFTER_SEND == S_DONE);
                        end else begin
                            i <= i + ONE;
                        end
                    end
                end
                S_SUM: begin
                    if (issue) begin
                        send_en <= 1'b1;
                        content <= sum;
                        state   <= S_DONE;
                        done    <= 1'b1;
                    end
                end
                S_DONE: begin
                    done <= 1'b1;
                end
                default: begin
                    state <= START_STATE;
                end
            endcase
        end
    end

    assign instr_mem.addr  = addr_q;
    assign io_send.en      = send_en;
    assign io_send.content = content;
    assign io_recv.en      = recv_en;

    // The cache port is not used by this core.
    assign cache.addr  = '0;
    assign cache.wdata = '0;
    assign cache.wr_en = 1'b0;
    assign cache.rd_en = 1'b0;

    logic unused_cache;
    assign unused_cache = ^cache.rdata;

endmodule

// File: tb/tb_loopback_dump_core.sv
// Bench for loopback_dump_core: three configurations (default, reversed,
// no-fetch/no-sum), UART receive models, instruction memory models and a
// per-instance expected-word queue checked on every send pulse.
module tb_loopback_dump_core;
    import core_pkg::*;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic a_reset = 1'b1;
    logic r_reset = 1'b1;
    logic z_reset = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- DUT instances ----------------
    IInstr       a_im ();
    ICache       a_ca ();
    ISendRequest a_tx ();
    IRecvRequest a_rx ();
    logic        a_done;
    dump_state_t a_state;

    IInstr       r_im ();
    ICache       r_ca ();
    ISendRequest r_tx ();
    IRecvRequest r_rx ();
    logic        r_done;
    dump_state_t r_state;

    IInstr       z_im ();
    ICache       z_ca ();
    ISendRequest z_tx ();
    IRecvRequest z_rx ();
    logic        z_done;
    dump_state_t z_state;

    loopback_dump_core u_a (
        .clock (clock), .reset (a_reset), .instr_mem (a_im), .cache (a_ca),
        .io_send (a_tx), .io_recv (a_rx), .done (a_done), .state (a_state)
    );

    loopback_dump_core #(.REVERSE(1)) u_r (
        .clock (clock), .reset (r_reset), .instr_mem (r_im), .cache (r_ca),
        .io_send (r_tx), .io_recv (r_rx), .done (r_done), .state (r_state)
    );

    loopback_dump_core #(.N_INSTR(0), .N_DATA(2), .APPEND_SUM(0)) u_z (
        .clock (clock), .reset (z_reset), .instr_mem (z_im), .cache (z_ca),
        .io_send (z_tx), .io_recv (z_rx), .done (z_done), .state (z_state)
    );

    // ---------------- scoreboard state ----------------
    logic [31:0] a_expq[$];
    logic [31:0] r_expq[$];
    logic [31:0] z_expq[$];
    logic [31:0] a_rxq[$];
    logic [31:0] r_rxq[$];
    logic [31:0] z_rxq[$];
    int          a_sends = 0;
    logic        a_busy_at_edge = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- memory / queue models ----------------
    logic [31:0] a_addr_s;
    logic [31:0] r_addr_s;
    initial begin
        a_im.instr = '0;
        forever begin
            @(negedge clock);
            a_addr_s = a_im.addr;
            @(posedge clock);
            #1;
            a_im.instr = 32'h1000 + a_addr_s;
        end
    end
    initial begin
        r_im.instr = '0;
        forever begin
            @(negedge clock);
            r_addr_s = r_im.addr;
            @(posedge clock);
            #1;
            r_im.instr = 32'h1000 + r_addr_s;
        end
    end
    initial begin
        z_im.instr  = '0;
        a_ca.rdata  = '0;
        r_ca.rdata  = '0;
        z_ca.rdata  = '0;
        r_tx.busy   = 1'b0;
        z_tx.busy   = 1'b0;
    end

    logic a_take;
    logic r_take;
    logic z_take;
    initial begin
        a_rx.size = '0;
        a_rx.rd   = '0;
        forever begin
            @(negedge clock);
            a_take = a_rx.en;
            @(posedge clock);
            #1;
            if (a_take === 1'b1 && a_rxq.size() > 0) void'(a_rxq.pop_front());
            a_rx.size = 32'(a_rxq.size());
            a_rx.rd   = (a_rxq.size() > 0) ? a_rxq[0] : 32'h0;
        end
    end
    initial begin
        r_rx.size = '0;
        r_rx.rd   = '0;
        forever begin
            @(negedge clock);
            r_take = r_rx.en;
            @(posedge clock);
            #1;
            if (r_take === 1'b1 && r_rxq.size() > 0) void'(r_rxq.pop_front());
            r_rx.size = 32'(r_rxq.size());
            r_rx.rd   = (r_rxq.size() > 0) ? r_rxq[0] : 32'h0;
        end
    end
    initial begin
        z_rx.size = '0;
        z_rx.rd   = '0;
        forever begin
            @(negedge clock);
            z_take = z_rx.en;
            @(posedge clock);
            #1;
            if (z_take === 1'b1 && z_rxq.size() > 0) void'(z_rxq.pop_front());
            z_rx.size = 32'(z_rxq.size());
            z_rx.rd   = (z_rxq.size() > 0) ? z_rxq[0] : 32'h0;
        end
    end

    // ---------------- send monitors ----------------
    always @(posedge clock) a_busy_at_edge = a_tx.busy;

    always @(negedge clock) begin : mon_a
        logic [31:0] w;
        if (a_tx.en === 1'b1) begin
            a_sends++;
            check("a_issue_while_busy", 32'(a_busy_at_edge), 32'h0);
            check("a_send_expected", 32'(a_expq.size() != 0), 32'h1);
            if (a_expq.size() != 0) begin
                w = a_expq.pop_front();
                check("a_send_word", a_tx.content, w);
                check("a_done_with_last", 32'(a_done), 32'(a_expq.size() == 0));
            end
        end
    end

    always @(negedge clock) begin : mon_r
        logic [31:0] w;
        if (r_tx.en === 1'b1) begin
            check("r_send_expected", 32'(r_expq.size() != 0), 32'h1);
            if (r_expq.size() != 0) begin
                w = r_expq.pop_front();
                check("r_send_word", r_tx.content, w);
            end
        end
    end

    always @(negedge clock) begin : mon_z
        logic [31:0] w;
        if (z_tx.en === 1'b1) begin
            check("z_send_expected", 32'(z_expq.size() != 0), 32'h1);
            if (z_expq.size() != 0) begin
                w = z_expq.pop_front();
                check("z_send_word", z_tx.content, w);
                check("z_done_with_last", 32'(z_done), 32'(z_expq.size() == 0));
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic fill_a_rx();
        a_rxq.delete();
        for (int d = 0; d < 10; d++) a_rxq.push_back(32'h20 + 32'(d));
    endtask

    // Expected stream for the default configuration, checksum from the model.
    task automatic push_a_expected();
        logic [31:0] s;
        s = '0;
        a_expq.delete();
        for (int a = 0; a < 10; a++) begin
            a_expq.push_back(32'h1000 + 32'(a));
            s = s + 32'h1000 + 32'(a);
        end
        for (int d = 0; d < 10; d++) begin
            a_expq.push_back(32'h20 + 32'(d));
            s = s + 32'h20 + 32'(d);
        end
        a_expq.push_back(s);
    endtask

    function automatic logic done_of(input int which);
        case (which)
            0:       return a_done;
            1:       return r_done;
            default: return z_done;
        endcase
    endfunction

    task automatic run_to_done(input string tag, input int which, input int budget);
        int n;
        n = 0;
        @(negedge clock);
        while (done_of(which) !== 1'b1 && n < budget) begin
            @(negedge clock);
            n++;
        end
        check(tag, 32'(done_of(which)), 32'h1);
        @(negedge clock);
        #1;
    endtask

    task automatic restart_a();
        @(posedge clock);
        #1;
        a_reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int          n;
        int          pops;
        int          span;
        int          cd;
        int          hi;
        logic        seen;
        logic [31:0] s;

        a_tx.busy = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);

        // reset state
        check("rst_addr",      a_im.addr,        32'h0);
        check("rst_send_en",   32'(a_tx.en),     32'h0);
        check("rst_content",   a_tx.content,     32'h0);
        check("rst_recv_en",   32'(a_rx.en),     32'h0);
        check("rst_done",      32'(a_done),      32'h0);
        check("rst_state",     32'(a_state),     32'(S_FETCH));
        check("rst_cache",     a_ca.addr | a_ca.wdata | 32'(a_ca.wr_en) | 32'(a_ca.rd_en), 32'h0);
        check("rst_r_state",   32'(r_state),     32'(S_FETCH));
        check("rst_z_skip",    32'(z_state),     32'(S_RECV));

        // default run: FETCH length, full echo, checksum, sticky done
        fill_a_rx();
        push_a_expected();
        @(posedge clock);
        #1;
        a_reset = 1'b0;
        n = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (a_state != S_FETCH) break;
            n++;
        end
        check("fetch_cycles", 32'(n), 32'd11);
        run_to_done("basic_done", 0, 300);
        check("basic_all_sent", 32'(a_expq.size()), 32'h0);
        repeat (5) @(negedge clock);
        check("done_sticky",   32'(a_done),  32'h1);
        check("done_addr",     a_im.addr,    32'h0);
        check("done_send_en",  32'(a_tx.en), 32'h0);
        check("done_recv_en",  32'(a_rx.en), 32'h0);

        // reset after the 5th send, then full replay
        restart_a();
        fill_a_rx();
        push_a_expected();
        a_sends = 0;
        a_reset = 1'b0;
        n = 0;
        while (a_sends < 5 && n < 300) begin
            @(negedge clock);
            #1;
            n++;
        end
        check("abort_reached_5", 32'(a_sends), 32'd5);
        a_reset = 1'b1;
        @(negedge clock);
        check("abort_send_en", 32'(a_tx.en),  32'h0);
        check("abort_done",    32'(a_done),   32'h0);
        check("abort_addr",    a_im.addr,     32'h0);
        check("abort_content", a_tx.content,  32'h0);
        check("abort_state",   32'(a_state),  32'(S_FETCH));
        fill_a_rx();
        push_a_expected();
        @(posedge clock);
        #1;
        a_reset = 1'b0;
        run_to_done("replay_done", 0, 300);
        check("replay_all_sent", 32'(a_expq.size()), 32'h0);

        // receive stall with an empty queue
        restart_a();
        a_rxq.delete();
        push_a_expected();
        a_reset = 1'b0;
        n = 0;
        while (a_state != S_RECV && n < 40) begin
            @(negedge clock);
            n++;
        end
        check("stall_reach_recv", 32'(a_state), 32'(S_RECV));
        for (int c = 0; c < 50; c++) begin
            @(negedge clock);
            check("stall_recv_en", 32'(a_rx.en), 32'h0);
            check("stall_no_send", 32'(a_tx.en), 32'h0);
        end
        fill_a_rx();
        pops = 0;
        span = 0;
        seen = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clock);
            if (a_state != S_RECV) break;
            if (a_rx.en === 1'b1) begin
                pops++;
                seen = 1'b1;
            end
            if (seen) span++;
        end
        check("stall_pops",  32'(pops), 32'd10);
        check("stall_span",  32'(span), 32'd10);
        check("stall_next",  32'(a_state), 32'(S_SEND));
        run_to_done("stall_done", 0, 300);
        check("stall_all_sent", 32'(a_expq.size()), 32'h0);

        // busy rises 3 cycles after a pulse and stays high for 5 cycles
        restart_a();
        fill_a_rx();
        push_a_expected();
        a_reset = 1'b0;
        cd = -1;
        hi = 0;
        n  = 0;
        while (a_done !== 1'b1 && n < 1000) begin
            @(negedge clock);
            #1;
            n++;
            if (hi > 0) begin
                hi--;
                if (hi == 0) a_tx.busy = 1'b0;
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    a_tx.busy = 1'b1;
                    hi = 5;
                    cd = -1;
                end
            end else if (a_tx.en === 1'b1) begin
                cd = 3;
            end
        end
        check("busy_done", 32'(a_done), 32'h1);
        repeat (2) @(negedge clock);
        check("busy_all_sent", 32'(a_expq.size()), 32'h0);
        a_tx.busy = 1'b0;

        // reversed order, same checksum
        r_rxq.delete();
        for (int d = 0; d < 10; d++) r_rxq.push_back(32'h20 + 32'(d));
        s = '0;
        for (int d = 9; d >= 0; d--) begin
            r_expq.push_back(32'h20 + 32'(d));
            s = s + 32'h20 + 32'(d);
        end
        for (int a = 9; a >= 0; a--) begin
            r_expq.push_back(32'h1000 + 32'(a));
            s = s + 32'h1000 + 32'(a);
        end
        r_expq.push_back(s);
        @(posedge clock);
        #1;
        r_reset = 1'b0;
        run_to_done("rev_done", 1, 300);
        check("rev_all_sent", 32'(r_expq.size()), 32'h0);

        // no fetch phase, no checksum word
        z_rxq.push_back(32'hFFFF_FFFF);
        z_rxq.push_back(32'h0000_0002);
        z_expq.push_back(32'hFFFF_FFFF);
        z_expq.push_back(32'h0000_0002);
        @(posedge clock);
        #1;
        z_reset = 1'b0;
        @(negedge clock);
        check("zero_fetch_addr", z_im.addr, 32'h0);
        run_to_done("zero_done", 2, 100);
        check("zero_all_sent", 32'(z_expq.size()), 32'h0);
        repeat (5) @(negedge clock);
        check("zero_no_sum_pulse", 32'(z_tx.en), 32'h0);
        check("zero_rx_drained", 32'(z_rxq.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
